uart_command_rx: RTL
====================

# uart_command_rx

Receiving end of the serial command/data link driven by the transmit side's `Comunicaciones` and `EnviarDatos` paths. Deserialises 8N1 UART frames from `rx` and assembles each two-byte packet into a command byte followed by a data byte. It then presents both bytes with a one-cycle valid strobe. Framing errors and inter-byte timeouts are reported as single-cycle error pulses. It sits at the board's serial input pin and feeds the command decoder.

## Interface
- `CLKS_PER_BIT`, default 5208: clock cycles per bit (50 MHz / 9600 baud); legal range ≥ 4, bit-centre offset is `CLKS_PER_BIT/2` (integer divide).
- `TIMEOUT_BITS`, default 20: maximum bit times allowed between the command stop-bit sample and the data start-bit falling edge.
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  reset, asynchronous and active-high.
- `rx`  in  1  serial input, idle high, asynchronous to `clk`.
- `command`  out  8  last received command byte.
- `datos`  out  8  last received data byte.
- `valid`  out  1  one-cycle pulse: `command`/`datos` hold a new packet.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `timeout`  out  1  one-cycle pulse: data byte did not start in time.
- `busy`  out  1  high while a byte is being received or a command awaits its data byte.

## Operation
- `rx` passes through a 2-flop synchroniser (`rx_s`); all logic uses `rx_s`.
- Byte FSM states:
  - IDLE: wait for `rx_s`==0.
  - START: count `CLKS_PER_BIT/2`-1 more cycles, then re-sample. If low, go to DATA. If high, treat it as a glitch and return to IDLE with no error.
  - DATA: sample every `CLKS_PER_BIT` cycles, 8 bits, LSB first, into a shift register.
  - STOP: sample after `CLKS_PER_BIT` cycles. A 1 gives byte_ok; a 0 gives byte_err. Return to IDLE on the same edge, so a start bit directly after the stop centre is caught.
- Bit counter is 3 bits. Baud counter width is `$clog2(CLKS_PER_BIT)`. It reloads on each sample and never wraps mid-bit.
- Packet FSM states:
  - WAIT_CMD, on byte_ok: latch byte into an internal command holding register, go to WAIT_DATA, clear the timeout counter.
  - WAIT_DATA, on byte_ok: load `command` from the holding register and `datos` from the byte, pulse `valid`, go to WAIT_CMD.
  - WAIT_DATA, while byte FSM is in IDLE: increment the timeout counter each cycle. At `TIMEOUT_BITS*CLKS_PER_BIT` cycles, pulse `timeout`, discard the held command, go to WAIT_CMD.
  - Timeout counting stops once a start bit is detected.
  - byte_err in any state: pulse `frame_err`, discard any held command, go to WAIT_CMD. `command`/`datos` are unchanged.
- `command`/`datos` change only on a `valid` cycle; they hold their value otherwise.
- `busy` = (byte FSM ≠ IDLE) OR (packet FSM = WAIT_DATA).

## Timing
- Reset: all outputs are 0, both FSMs are idle (IDLE / WAIT_CMD), synchroniser flops are 1, counters are 0. Reset asserted mid-frame aborts immediately. No pulse is generated on or after release.
- Let t0 be the first cycle with `rx_s`==0 in IDLE (2–3 cycles after the `rx` edge).
  - Start re-check: t0+`CLKS_PER_BIT/2`.
  - Data bit i (i = 0..7): t0+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop bit: t0+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- `valid`, `frame_err` and `timeout` are registered. Each is high exactly the one cycle after the stop sample (or after the timeout count is reached). The three are mutually exclusive.
- When a timeout and a start detection fall on the same cycle, the start wins: no timeout, and the byte is received as data.
- Tolerance: at most ±4% baud mismatch with the sender.

## Test plan
(All scenarios use `CLKS_PER_BIT`=16, `TIMEOUT_BITS`=4.)
- Nominal packet: send 0x09 then 0x31 with 2 idle bits between. Expect one `valid` pulse 1 cycle after the second stop sample, with `command`=0x09 and `datos`=0x31. `busy` is 0 afterwards.
- Glitch: drive `rx` low for 3 cycles. Expect no `valid`/`frame_err`, and `busy` returns to 0 by t0+9.
- Framing error: send 0x09 correctly, then 0x31 with stop bit 0. Expect a `frame_err` pulse, no `valid`, and outputs unchanged. Then send 0x05, 0xA5 → `valid` with 0x05/0xA5.
- Timeout: send 0x09, then hold `rx` high for more than 64 cycles. Expect a `timeout` pulse at 64 cycles after the stop sample. A following 0x07, 0x3C → `valid` with `command`=0x07 and `datos`=0x3C.
- Reset mid-byte: assert `rst` during bit 4 of the data byte. Expect all outputs 0 immediately and no pulses. After release, 0x09, 0x31 is received correctly.
- Back-to-back: send two packets (0x01/0x02, 0x03/0x04) with zero idle time, each start bit directly after the previous stop bit. Expect two `valid` pulses with the correct bytes each time.

Source files
------------

// File: rtl/uart_command_rx.sv
// uart_command_rx: 8N1 UART receiver that pairs bytes into command/data packets.
// Ports:
//   clk, rst        - system clock, asynchronous active-high reset
//   rx              - serial input, idle high, asynchronous to clk
//   command, datos  - last received command / data byte (change only with valid)
//   valid           - one-cycle pulse: a new command/data packet is presented
//   frame_err       - one-cycle pulse: a stop bit was sampled low
//   timeout         - one-cycle pulse: the data byte did not start in time
//   busy            - a byte is in flight or a command is waiting for its data
module uart_command_rx #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] command,
  output logic [7:0] datos,
  output logic       valid,
  output logic       frame_err,
  output logic       timeout,
  output logic       busy
);

  localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF     = CLKS_PER_BIT / 2;
  localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(HALF - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TO_LIMIT - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;
  typedef enum logic {P_WAIT_CMD, P_WAIT_DATA} pkt_state_t;

  byte_state_t byte_state, byte_next;
  pkt_state_t  pkt_state, pkt_next;

  logic              rx_meta, rx_s;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [7:0]        cmd_hold;
  logic [TO_W-1:0]   to_cnt;

  logic start_det, half_hit, bit_hit, byte_ok, byte_err, to_hit;
  logic valid_d, frame_err_d, timeout_d, busy_d, hold_load;

  // Two-flop synchroniser, idles high so reset looks like a quiet line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Sampling strobes shared by both FSMs
  assign start_det = (byte_state == B_IDLE) && !rx_s;
  assign half_hit  = (byte_state == B_START) && (baud_cnt == HALF_LAST);
  assign bit_hit   = (baud_cnt == BAUD_LAST);
  assign byte_ok   = (byte_state == B_STOP) && bit_hit && rx_s;
  assign byte_err  = (byte_state == B_STOP) && bit_hit && !rx_s;
  // A start detection on the last count cycle suppresses the timeout
  assign to_hit    = (pkt_state == P_WAIT_DATA) && (byte_state == B_IDLE) && rx_s &&
                     (to_cnt == TO_LAST);

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_state <= B_IDLE;
      pkt_state  <= P_WAIT_CMD;
    end else begin
      byte_state <= byte_next;
      pkt_state  <= pkt_next;
    end
  end

  // Next-state logic for the byte and packet FSMs
  always_comb begin
    byte_next = byte_state;
    pkt_next  = pkt_state;
    case (byte_state)
      B_IDLE:  if (!rx_s) byte_next = B_START;
      B_START: if (half_hit) byte_next = rx_s ? B_IDLE : B_DATA;
      B_DATA:  if (bit_hit && (bit_cnt == 3'd7)) byte_next = B_STOP;
      B_STOP:  if (bit_hit) byte_next = B_IDLE;
      default: byte_next = B_IDLE;
    endcase
    case (pkt_state)
      P_WAIT_CMD:  if (byte_ok) pkt_next = P_WAIT_DATA;
      P_WAIT_DATA: if (byte_ok || byte_err || to_hit) pkt_next = P_WAIT_CMD;
      default:     pkt_next = P_WAIT_CMD;
    endcase
  end

  // Output decode; busy is registered from next state so it tracks the FSMs exactly
  always_comb begin
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    timeout_d   = 1'b0;
    hold_load   = 1'b0;
    busy_d      = (byte_next != B_IDLE) || (pkt_next == P_WAIT_DATA);
    if (byte_err) begin
      frame_err_d = 1'b1;
    end else if (byte_ok) begin
      if (pkt_state == P_WAIT_DATA) valid_d = 1'b1;
      else                          hold_load = 1'b1;
    end else if (to_hit) begin
      timeout_d = 1'b1;
    end
  end

  // Baud/bit counters, shift register, command holding register, timeout counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      cmd_hold <= '0;
      to_cnt   <= '0;
    end else begin
      if (byte_state == B_IDLE || half_hit || bit_hit) baud_cnt <= '0;
      else                                             baud_cnt <= baud_cnt + BAUD_W'(1);

      if (byte_state == B_IDLE) begin
        bit_cnt <= '0;
      end else if (byte_state == B_DATA && bit_hit) begin
        shift   <= {rx_s, shift[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (hold_load) cmd_hold <= shift;

      if (pkt_state == P_WAIT_CMD)                 to_cnt <= '0;
      else if (byte_state == B_IDLE && !start_det) to_cnt <= to_cnt + TO_W'(1);
    end
  end

  // Registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      command   <= '0;
      datos     <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      valid     <= valid_d;
      frame_err <= frame_err_d;
      timeout   <= timeout_d;
      busy      <= busy_d;
      if (valid_d) begin
        command <= cmd_hold;
        datos   <= shift;
      end
    end
  end

endmodule
